tdc_binner: RTL and testbench
=============================

TDC_BINNER -- requirements
Module: tdc_binner

Interface
REQ-001 SHALL have parameter BIN_SHIFT, default 0: each histogram bin spans 2^BIN_SHIFT clk ticks (legal 0..7).
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the event and overflow counters.
REQ-003 SHALL have port clk  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_in  in  1  asynchronous sync/laser pulse that opens a timing window.
REQ-006 SHALL have port stop_in  in  1  asynchronous photon-detector pulse that closes a timing window.
REQ-007 SHALL have port Command  in  2  control code: 2'b10 run, 2'b01 clear, other values stop.
REQ-008 SHALL have port addr  out  8  bin index for the downstream histogram memory.
REQ-009 SHALL have port Memory_add  out  1  one-cycle increment strobe for the downstream histogram memory.
REQ-010 SHALL have port busy  out  1  high while a timing window is open (ARMED).
REQ-011 SHALL have port event_cnt  out  CNT_WIDTH  count of accepted stops.
REQ-012 SHALL have port overflow_cnt  out  CNT_WIDTH  count of timed-out windows.

Function
REQ-013 SHALL pass each of start_in and stop_in through a 2-flop synchronizer (s1, s2) plus a delay flop s3; pulse = s2 & ~s3, one cycle per rising edge.
REQ-014 SHALL implement states IDLE, ARMED and EMIT, with a tick counter of 9+BIN_SHIFT bits.
REQ-015 SHALL, in IDLE with Command==2'b10 and start pulse high, load tick=1 and enter ARMED; stop pulses in IDLE are ignored.
REQ-016 SHALL, in ARMED, increment tick by 1 every cycle; busy = (state==ARMED).
REQ-017 SHALL, in ARMED with stop pulse high, register addr = tick>>BIN_SHIFT, enter EMIT, and increment event_cnt.
REQ-018 SHALL, when start and stop pulses rise a sampled delay of D cycles apart, produce addr = D>>BIN_SHIFT.
REQ-019 SHALL, in ARMED with no stop pulse and tick == (256<<BIN_SHIFT)-1, return to IDLE, increment overflow_cnt, and produce no strobe.
REQ-020 SHALL give a stop pulse priority over a start pulse when both are high in the same ARMED cycle; the start pulse is dropped.
REQ-021 SHALL, on a start pulse alone in ARMED, re-arm with tick=1 and no count change.
REQ-022 SHALL assert Memory_add for exactly the single EMIT cycle, then enter IDLE; at most one strobe per window.
REQ-023 SHALL hold addr stable between strobes.
REQ-024 SHALL, with Command != 2'b10, let an open window complete normally but accept no new arm.
REQ-025 SHALL treat Command==2'b01 as synchronous clear with highest priority: next state IDLE, tick=0, Memory_add=0, event_cnt=0, overflow_cnt=0, addr=0.
REQ-026 SHALL saturate event_cnt and overflow_cnt at all-ones.
REQ-027 SHALL produce Memory_add high in the cycle following the 3rd clk edge that samples stop_in high, i.e. 3 cycles of latency from input to strobe.

Reset
REQ-028 SHALL, on rst high, immediately and asynchronously force: state IDLE; tick, addr, event_cnt, overflow_cnt = 0; Memory_add, busy = 0; all synchronizer flops = 0.
REQ-029 SHALL, on rst asserted mid-window, discard the window with no strobe; operation resumes on the first start pulse after rst release.

Verification
REQ-030 SHALL cover: assert rst during ARMED -> busy=0, Memory_add=0, addr=0, both counters 0 in the same cycle.
REQ-031 SHALL cover: BIN_SHIFT=0, Command=10, start rise then stop rise 37 cycles later -> one Memory_add pulse with addr=37, 3 cycles after the stop sample edge; event_cnt=1.
REQ-032 SHALL cover: BIN_SHIFT=2, same 37-cycle stimulus -> addr=9, single strobe.
REQ-033 SHALL cover: BIN_SHIFT=0, start with no stop -> busy high 255 cycles then low; overflow_cnt=1; no strobe; late stop ignored.
REQ-034 SHALL cover: start, second start 10 cycles later, stop 20 cycles after the second start -> addr=20; start and stop coinciding in ARMED -> strobe issued, no re-arm.
REQ-035 SHALL cover: Command=01 pulsed while ARMED -> busy=0 next cycle, counters 0; subsequent stop gives no Memory_add.

Source files
------------

// File: rtl/tdc_binner.sv
// -----------------------------------------------------------------------------
// tdc_binner
//
// Time-to-digital converter front end for a photon-timing histogram. A start
// pulse (laser sync) opens a timing window and a stop pulse (detector hit)
// closes it. The elapsed tick count is binned by 2^BIN_SHIFT and handed to
// a downstream histogram memory as an address plus a one-cycle increment
// strobe. Windows that see no stop before the last bin are dropped and
// counted as overflows.
//
// Parameters
//   BIN_SHIFT    log2 of the bin width in clk ticks (0..7)
//   CNT_WIDTH    width of event_cnt / overflow_cnt
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   start_in     asynchronous start pulse (opens a window)
//   stop_in      asynchronous stop pulse (closes a window)
//   Command      2'b10 run, 2'b01 synchronous clear, anything else stop
//   addr         bin index, held stable between strobes
//   Memory_add   one-cycle increment strobe for the histogram memory
//   busy         high while a timing window is open
//   event_cnt    saturating count of accepted stops
//   overflow_cnt saturating count of timed-out windows
// -----------------------------------------------------------------------------
module tdc_binner #(
    parameter int BIN_SHIFT = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_in,
    input  logic                 stop_in,
    input  logic [1:0]           Command,
    output logic [7:0]           addr,
    output logic                 Memory_add,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] event_cnt,
    output logic [CNT_WIDTH-1:0] overflow_cnt
);

    localparam int TW = 9 + BIN_SHIFT;
    // Last tick that still falls inside bin 255.
    localparam logic [TW-1:0] TICK_MAX = TW'((32'd256 << BIN_SHIFT) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [TW-1:0] tick, tick_nxt;
    logic [7:0]    addr_nxt;
    logic          strobe_nxt;
    logic          ev_inc;
    logic          ov_inc;

    // Synchronizer chains: [0]=s1, [1]=s2, [2]=s3 (edge-detect delay flop).
    logic [2:0] start_sync;
    logic [2:0] stop_sync;
    logic       start_pulse;
    logic       stop_pulse;

    logic cmd_run;
    logic cmd_clear;

    assign cmd_run     = (Command == 2'b10);
    assign cmd_clear   = (Command == 2'b01);
    assign start_pulse = start_sync[1] & ~start_sync[2];
    assign stop_pulse  = stop_sync[1]  & ~stop_sync[2];
    assign busy        = (state == ARMED);

    // NOTE: every clocked block uses non-blocking (<=) assignments so all flops
    // update together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '0;
            stop_sync  <= '0;
        end else begin
            start_sync <= {start_sync[1:0], start_in};
            stop_sync  <= {stop_sync[1:0],  stop_in};
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick;
        addr_nxt   = addr;
        strobe_nxt = 1'b0;
        ev_inc     = 1'b0;
        ov_inc     = 1'b0;

        if (cmd_clear) begin
            state_nxt = IDLE;
            tick_nxt  = '0;
            addr_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Stops are ignored here; only a run command may arm.
                    if (cmd_run && start_pulse) begin
                        tick_nxt  = TW'(1);
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    // A stop wins over a simultaneous start; that start is lost.
                    if (stop_pulse) begin
                        addr_nxt   = 8'(tick >> BIN_SHIFT);
                        strobe_nxt = 1'b1;
                        ev_inc     = 1'b1;
                        state_nxt  = EMIT;
                    end else if (start_pulse) begin
                        tick_nxt = TW'(1);
                    end else if (tick == TICK_MAX) begin
                        ov_inc    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                EMIT: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            addr       <= '0;
            Memory_add <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick       <= tick_nxt;
            addr       <= addr_nxt;
            // Registered so the strobe is high exactly for the EMIT cycle.
            Memory_add <= strobe_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt    <= '0;
            overflow_cnt <= '0;
        end else if (cmd_clear) begin
            event_cnt    <= '0;
            overflow_cnt <= '0;
        end else begin
            if (ev_inc && (event_cnt != '1)) begin
                event_cnt <= event_cnt + 1'b1;
            end
            if (ov_inc && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_binner.sv
// -----------------------------------------------------------------------------
// tb_tdc_binner
//
// Drives two tdc_binner instances from the same stimulus:
//   u_b0 : BIN_SHIFT=0, CNT_WIDTH=16
//   u_b2 : BIN_SHIFT=2, CNT_WIDTH=2  (small counters so saturation is reachable)
// Every stop that should produce a strobe pushes {addr, strobe cycle} to a
// per-instance queue; a negedge monitor pops and compares on each strobe.
// -----------------------------------------------------------------------------
module tb_tdc_binner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;
    logic [1:0]  Command = 2'b00;

    logic [7:0]  b0_addr, b2_addr;
    logic        b0_madd, b2_madd;
    logic        b0_busy, b2_busy;
    logic [15:0] b0_ev, b0_ov;
    logic [1:0]  b2_ev, b2_ov;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] addr;
        int         cyc;
    } exp_t;

    typedef struct {
        int         d;
        logic [7:0] a0;
        logic [7:0] a2;
    } vec_t;

    exp_t q0[$];
    exp_t q2[$];

    tdc_binner #(.BIN_SHIFT(0), .CNT_WIDTH(16)) u_b0 (
        .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
        .Command(Command), .addr(b0_addr), .Memory_add(b0_madd),
        .busy(b0_busy), .event_cnt(b0_ev), .overflow_cnt(b0_ov)
    );

    tdc_binner #(.BIN_SHIFT(2), .CNT_WIDTH(2)) u_b2 (
        .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
        .Command(Command), .addr(b2_addr), .Memory_add(b2_madd),
        .busy(b2_busy), .event_cnt(b2_ev), .overflow_cnt(b2_ov)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at the negedge where stop_in is raised; the strobe is due three
    // rising edges later.
    task automatic push(input logic [7:0] a0, input logic [7:0] a2);
        exp_t e0, e2;
        e0.addr = a0; e0.cyc = cyc + 3;
        e2.addr = a2; e2.cyc = cyc + 3;
        q0.push_back(e0);
        q2.push_back(e2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b0_madd) begin
                if (q0.size() == 0) check("u_b0 unexpected strobe", 32'(b0_madd), 32'd0);
                else begin
                    e = q0.pop_front();
                    check("u_b0 addr", 32'(b0_addr), 32'(e.addr));
                    check("u_b0 strobe cycle", cyc, e.cyc);
                end
            end
            if (b2_madd) begin
                if (q2.size() == 0) check("u_b2 unexpected strobe", 32'(b2_madd), 32'd0);
                else begin
                    e = q2.pop_front();
                    check("u_b2 addr", 32'(b2_addr), 32'(e.addr));
                    check("u_b2 strobe cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One start/stop window with stop raised d cycles after start. If
    // cmd_off_at > 0, Command drops to stop mid-window at that offset.
    task automatic window(input int d, input logic [7:0] a0, input logic [7:0] a2,
                          input int cmd_off_at);
        @(negedge clk);
        start_in = 1'b1;
        for (int k = 1; k <= d + 2; k++) begin
            @(negedge clk);
            if (k == 2) start_in = 1'b0;
            if (k == cmd_off_at) Command = 2'b00;
            if (k == d) begin
                stop_in = 1'b1;
                push(a0, a2);
            end
            if (k == d + 2) stop_in = 1'b0;
        end
        start_in = 1'b0;
        stop_in  = 1'b0;
        Command  = 2'b10;
        repeat (8) @(negedge clk);
    endtask

    task automatic stop_only();
        @(negedge clk);
        stop_in = 1'b1;
        repeat (2) @(negedge clk);
        stop_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " u_b0 busy"}, 32'(b0_busy), 32'd0);
        check({tag, " u_b0 Memory_add"}, 32'(b0_madd), 32'd0);
        check({tag, " u_b0 addr"}, 32'(b0_addr), 32'd0);
        check({tag, " u_b0 event_cnt"}, 32'(b0_ev), 32'd0);
        check({tag, " u_b0 overflow_cnt"}, 32'(b0_ov), 32'd0);
        check({tag, " u_b2 busy"}, 32'(b2_busy), 32'd0);
        check({tag, " u_b2 Memory_add"}, 32'(b2_madd), 32'd0);
        check({tag, " u_b2 addr"}, 32'(b2_addr), 32'd0);
        check({tag, " u_b2 event_cnt"}, 32'(b2_ev), 32'd0);
        check({tag, " u_b2 overflow_cnt"}, 32'(b2_ov), 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int   bc0, bc2;

        vecs[0] = '{d: 1,   a0: 8'd1,   a2: 8'd0};
        vecs[1] = '{d: 2,   a0: 8'd2,   a2: 8'd0};
        vecs[2] = '{d: 5,   a0: 8'd5,   a2: 8'd1};
        vecs[3] = '{d: 37,  a0: 8'd37,  a2: 8'd9};
        vecs[4] = '{d: 100, a0: 8'd100, a2: 8'd25};
        vecs[5] = '{d: 200, a0: 8'd200, a2: 8'd50};
        vecs[6] = '{d: 255, a0: 8'd255, a2: 8'd63};

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #3 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        Command = 2'b10;
        repeat (4) @(negedge clk);

        // Binning across the range; u_b2 event counter saturates at 3.
        foreach (vecs[i]) window(vecs[i].d, vecs[i].a0, vecs[i].a2, 0);
        check("table u_b0 event_cnt", 32'(b0_ev), 32'd7);
        check("table u_b2 event_cnt saturated", 32'(b2_ev), 32'd3);
        check("table u_b0 overflow_cnt", 32'(b0_ov), 32'd0);
        check("table u_b2 overflow_cnt", 32'(b2_ov), 32'd0);

        // Command leaves run mid-window: the open window still completes.
        window(12, 8'd12, 8'd3, 5);
        check("cmd-stop window u_b0 event_cnt", 32'(b0_ev), 32'd8);

        // Command not run: a start must not arm.
        Command = 2'b00;
        @(negedge clk);
        start_in = 1'b1;
        repeat (2) @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        check("no-run u_b0 busy", 32'(b0_busy), 32'd0);
        check("no-run u_b2 busy", 32'(b2_busy), 32'd0);
        Command = 2'b10;
        repeat (4) @(negedge clk);

        // Re-arm: second start 10 cycles after the first, stop 20 after that.
        @(negedge clk);
        start_in = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 2)  start_in = 1'b0;
            if (k == 10) start_in = 1'b1;
            if (k == 12) start_in = 1'b0;
            if (k == 30) begin
                stop_in = 1'b1;
                push(8'd20, 8'd5);
            end
            if (k == 32) stop_in = 1'b0;
        end
        repeat (8) @(negedge clk);
        check("re-arm u_b0 event_cnt", 32'(b0_ev), 32'd9);

        // Start and stop together in ARMED: stop wins, no re-arm, addr held.
        @(negedge clk);
        start_in = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 2) start_in = 1'b0;
            if (k == 15) begin
                start_in = 1'b1;
                stop_in  = 1'b1;
                push(8'd15, 8'd3);
            end
            if (k == 17) begin
                start_in = 1'b0;
                stop_in  = 1'b0;
            end
            if (k == 20) begin
                check("coincide u_b0 no re-arm", 32'(b0_busy), 32'd0);
                check("coincide u_b2 no re-arm", 32'(b2_busy), 32'd0);
            end
        end
        check("coincide u_b0 addr held", 32'(b0_addr), 32'd15);
        check("coincide u_b2 addr held", 32'(b2_addr), 32'd3);
        check("coincide u_b0 event_cnt", 32'(b0_ev), 32'd10);
        repeat (4) @(negedge clk);

        // Synchronous clear while ARMED; the following stop is ignored.
        @(negedge clk);
        start_in = 1'b1;
        repeat (2) @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-clear u_b0 busy", 32'(b0_busy), 32'd1);
        check("pre-clear u_b2 busy", 32'(b2_busy), 32'd1);
        Command = 2'b01;
        @(negedge clk);
        Command = 2'b10;
        check_all_zero("clear");
        stop_only();

        // Asynchronous reset mid-window.
        window(3, 8'd3, 8'd0, 0);
        check("pre-reset u_b0 event_cnt", 32'(b0_ev), 32'd1);
        @(negedge clk);
        start_in = 1'b1;
        repeat (2) @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset u_b0 busy", 32'(b0_busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("mid-window reset");
        @(negedge clk);
        rst = 1'b0;
        stop_only();

        // Timeout: no stop. u_b0 stays busy 255 cycles, u_b2 1023 cycles.
        @(negedge clk);
        start_in = 1'b1;
        bc0 = 0;
        bc2 = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (k == 2) start_in = 1'b0;
            if (b0_busy) bc0++;
            if (b2_busy) bc2++;
        end
        check("timeout u_b0 busy cycles", bc0, 32'd255);
        check("timeout u_b2 busy cycles", bc2, 32'd1023);
        check("timeout u_b0 overflow_cnt", 32'(b0_ov), 32'd1);
        check("timeout u_b2 overflow_cnt", 32'(b2_ov), 32'd1);
        stop_only();
        check("late stop u_b0 event_cnt", 32'(b0_ev), 32'd0);
        check("late stop u_b2 event_cnt", 32'(b2_ev), 32'd0);

        check("u_b0 strobes outstanding", q0.size(), 32'd0);
        check("u_b2 strobes outstanding", q2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
